display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 40 ++++
 rtl/display_scan_controller_if.sv | 9 +
 rtl/digit_scanner.sv | 55 +++++
 rtl/display_scan_controller.sv | 102 ++++++++++
 tb/tb_display_scan_controller.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants, codes and types for the display scan controller.
package display_pkg;

  localparam int unsigned FIELD_W    = 2;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [FIELD_W-1:0] FIELD_RIGHT = 2'd0;
  localparam logic [FIELD_W-1:0] FIELD_MID   = 2'd1;
  localparam logic [FIELD_W-1:0] FIELD_LEFT  = 2'd2;
  localparam logic [FIELD_W-1:0] FIELD_NONE  = 2'd3;

  localparam logic [DIGIT_W-1:0] CODE_A      = 4'd10;
  localparam logic [DIGIT_W-1:0] CODE_P      = 4'd11;
  localparam logic [DIGIT_W-1:0] CODE_HYPHEN = 4'd12;
  localparam logic [DIGIT_W-1:0] CODE_OFF    = 4'd15;

  // Six digit codes, digit 0 in the low nibble.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_buf_t;

  localparam digit_buf_t ALL_OFF = {NUM_DIGITS{CODE_OFF}};

  typedef enum logic [1:0] {
    FETCH_ISSUE   = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_CAPTURE = 2'd2
  } fetch_state_e;

  // Fetch order: LEFT -> MID -> RIGHT -> LEFT.
  function automatic logic [FIELD_W-1:0] next_field(input logic [FIELD_W-1:0] f);
    logic [FIELD_W-1:0] n;
    case (f)
      FIELD_LEFT: n = FIELD_MID;
      FIELD_MID:  n = FIELD_RIGHT;
      default:    n = FIELD_LEFT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Field-select request and registered digit-code response of the generator.
interface display_scan_controller_if;
  logic [1:0] target;
  logic [3:0] high_result;
  logic [3:0] low_result;

  modport master (output target, input high_result, input low_result);
  modport slave  (input target, output high_result, output low_result);
endinterface

// File: rtl/digit_scanner.sv
// Digit multiplexer: scan index, one-hot enable, buffer read and blink masking.
module digit_scanner
  import display_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  digit_buf_t            disp_buf,
  input  logic                  blink_en,
  input  logic [FIELD_W-1:0]    blink_field,
  input  logic                  blink_phase,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [DIGIT_W-1:0]    digit_val
);

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [DIGIT_W-1:0]    val_q, val_d;

  // Next index, decoded enable and masked code; disp_buf is the buffer's next
  // value so a commit and a coincident tick appear together one cycle later.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    sel_d = NUM_DIGITS'(1) << idx_d;
    val_d = disp_buf[idx_d];
    // Digit pairs map to fields by index/2: {5,4}=LEFT, {3,2}=MID, {1,0}=RIGHT.
    if (blink_en && !blink_phase && (blink_field != FIELD_NONE) &&
        (idx_d[IDX_W-1:1] == blink_field)) begin
      val_d = CODE_OFF;
    end
  end

  // Scan registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      sel_q <= NUM_DIGITS'(1);
      val_q <= CODE_OFF;
    end else begin
      idx_q <= idx_d;
      sel_q <= sel_d;
      val_q <= val_d;
    end
  end

  assign digit_sel = sel_q;
  assign digit_val = val_q;

endmodule

// File: rtl/display_scan_controller.sv
// Fetches three generator fields into a shadow buffer, commits whole frames
// to the display buffer and multiplexes the six digits.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..7
)
(
  input  logic                     clk,
  input  logic                     reset,
  display_scan_controller_if.master gen,
  input  logic                     tick,
  input  logic                     blink_en,
  input  logic [FIELD_W-1:0]       blink_field,
  input  logic                     blink_phase,
  output logic [NUM_DIGITS-1:0]    digit_sel,
  output logic [DIGIT_W-1:0]       digit_val,
  output logic                     frame_done
);

  localparam int unsigned WAIT_W = 3;
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [FIELD_W-1:0] target_q, target_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  digit_buf_t         shadow_q, shadow_d;
  digit_buf_t         display_q, display_d;
  logic               frame_done_q, frame_done_d;

  // Fetch sequencing, shadow capture and frame commit.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    wait_cnt_d   = wait_cnt_q;
    shadow_d     = shadow_q;
    display_d    = display_q;
    frame_done_d = 1'b0;
    case (state_q)
      FETCH_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (wait_cnt_q == SETTLE_LAST) begin
          state_d = FETCH_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      FETCH_CAPTURE: begin
        // Field f owns digits 2f+1 (high code) and 2f (low code).
        shadow_d[{target_q, 1'b1}] = gen.high_result;
        shadow_d[{target_q, 1'b0}] = gen.low_result;
        if (target_q == FIELD_RIGHT) begin
          display_d    = shadow_d;
          frame_done_d = 1'b1;
        end
        target_d = next_field(target_q);
        state_d  = FETCH_ISSUE;
      end
      default: begin
        state_d = FETCH_ISSUE;
      end
    endcase
  end

  // Fetch and buffer registers; reset restarts the pass at LEFT with blank buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_ISSUE;
      target_q     <= FIELD_LEFT;
      wait_cnt_q   <= '0;
      shadow_q     <= ALL_OFF;
      display_q    <= ALL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      wait_cnt_q   <= wait_cnt_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gen.target = target_q;
  assign frame_done = frame_done_q;

  digit_scanner u_scanner (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .disp_buf    (display_d),
    .blink_en    (blink_en),
    .blink_field (blink_field),
    .blink_phase (blink_phase),
    .digit_sel   (digit_sel),
    .digit_val   (digit_val)
  );

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a behavioural field generator.
module tb_display_scan_controller;
  import display_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       blink_en = 1'b0;
  logic [1:0] blink_field = 2'd3;
  logic       blink_phase = 1'b1;
  logic [5:0] digit_sel;
  logic [3:0] digit_val;
  logic       frame_done;

  logic gen_mode = 1'b0;  // 0: high=target+1, low=target+4; 1: both 7
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Expected digits 0..5 for the default generator.
  int   exp_d [6] = '{4, 1, 5, 2, 6, 3};
  logic [5:0] one_hot = 6'd1;

  display_scan_controller_if gen_if ();

  display_scan_controller #(.SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .gen         (gen_if),
    .tick        (tick),
    .blink_en    (blink_en),
    .blink_field (blink_field),
    .blink_phase (blink_phase),
    .digit_sel   (digit_sel),
    .digit_val   (digit_val),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Generator with one cycle of latency.
  always @(posedge clk) begin
    gen_if.high_result <= gen_mode ? 4'd7 : 4'(gen_if.target) + 4'd1;
    gen_if.low_result  <= gen_mode ? 4'd7 : 4'(gen_if.target) + 4'd4;
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    int ev;

    // Reset state.
    repeat (3) step();
    check("reset_sel", 32'(digit_sel), 32'd1);
    check("reset_val", 32'(digit_val), 32'd15);
    check("reset_fd", 32'(frame_done), 32'd0);
    check("reset_target", 32'(gen_if.target), 32'd2);

    // First frame with no ticks.
    reset = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 11; c++) begin
      step();
      check("pre_fd", 32'(frame_done), 32'd0);
      check("pre_val", 32'(digit_val), 32'd15);
      check("pre_target", 32'(gen_if.target), (c < 4) ? 32'd2 : (c < 8) ? 32'd1 : 32'd0);
    end
    check("pre_sel", 32'(digit_sel), 32'd1);
    step();
    check("commit_fd", 32'(frame_done), 32'd1);
    check("commit_val", 32'(digit_val), 32'd4);
    check("commit_sel", 32'(digit_sel), 32'd1);
    step();
    check("fd_pulse_end", 32'(frame_done), 32'd0);

    // Scan all six digits and wrap.
    for (int k = 1; k <= 6; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      idx = k % 6;
      check("scan_sel", 32'(digit_sel), 32'(one_hot << idx));
      check("scan_val", 32'(digit_val), 32'(exp_d[idx]));
    end

    // Blink MID field: hidden, then shown.
    blink_en = 1'b1;
    blink_field = FIELD_MID;
    for (int ph = 0; ph < 2; ph++) begin
      blink_phase = ph[0];
      for (int k = 1; k <= 6; k++) begin
        tick = 1'b1;
        step();
        tick = 1'b0;
        idx = k % 6;
        ev = (ph == 0 && (idx == 2 || idx == 3)) ? 15 : exp_d[idx];
        check("blink_sel", 32'(digit_sel), 32'(one_hot << idx));
        check("blink_val", 32'(digit_val), 32'(ev));
      end
    end
    blink_en = 1'b0;
    blink_field = 2'd3;
    blink_phase = 1'b1;

    // Align to MID WAIT, then reset with new generator values and tick held.
    for (int g = 0; g < 24 && (cyc % 12) != 5; g++) step();
    check("align_mid_target", 32'(gen_if.target), 32'd1);
    reset = 1'b1;
    tick = 1'b1;
    gen_mode = 1'b1;
    step();
    step();
    check("rst2_sel", 32'(digit_sel), 32'd1);
    check("rst2_val", 32'(digit_val), 32'd15);
    check("rst2_fd", 32'(frame_done), 32'd0);
    check("rst2_target", 32'(gen_if.target), 32'd2);

    reset = 1'b0;
    tick = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 11; c++) begin
      step();
      check("rst2_pre_fd", 32'(frame_done), 32'd0);
      check("rst2_no_mix", 32'(digit_val), 32'd15);
    end

    // Tick coincident with the commit edge.
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("tc_fd", 32'(frame_done), 32'd1);
    check("tc_sel", 32'(digit_sel), 32'd2);
    check("tc_val", 32'(digit_val), 32'd7);
    for (int k = 2; k <= 6; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      idx = k % 6;
      check("new_frame_sel", 32'(digit_sel), 32'(one_hot << idx));
      check("new_frame_val", 32'(digit_val), 32'd7);
    end
    check("new_frame_fd_low", 32'(frame_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
